ui_pix_conv: RTL and testbench

//  Streaming RGB pixel-depth reducer: IN_W bits/channel in, R_W/G_W/B_W bits out, packed {R,G,B}.

---
 rtl/ui_pix_pkg.sv | 28 ++
 rtl/ui_chan_quant.sv | 68 ++++++
 rtl/ui_pix_conv.sv | 124 ++++++++++++
 tb/tb_ui_pix_conv.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ui_pix_pkg.sv
// ============================================================================
// Module  : ui_pix_pkg
// Brief   : Shared quantisation mode codes and 2x2 ordered-dither table.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ui_pix_pkg;

    localparam logic [1:0] MODE_TRUNC  = 2'd0;
    localparam logic [1:0] MODE_ROUND  = 2'd1;
    localparam logic [1:0] MODE_DITHER = 2'd2;

    // Bayer = {{0,2},{3,1}}, indexed [y][x]
    function automatic logic [1:0] bayer_val(input logic y, input logic x);
        logic [1:0] r_val;
        case ({y, x})
            2'b00:   r_val = 2'd0;
            2'b01:   r_val = 2'd2;
            2'b10:   r_val = 2'd3;
            default: r_val = 2'd1;
        endcase
        return r_val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ui_chan_quant.sv
// ============================================================================
// Module  : ui_chan_quant
// Brief   : One colour channel: registered offset sum, then saturate and shift.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ui_chan_quant
    import ui_pix_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [IN_W-1:0]   pix_in,
    input  logic [1:0]        mode,
    input  logic [1:0]        bayer,
    output logic [OUT_W-1:0]  pix_out,
    output logic              sat
);

    localparam int c_D = IN_W - OUT_W;

    logic [IN_W:0] w_rnd_off;
    logic [IN_W:0] w_dith_off;
    logic [IN_W:0] w_off;
    logic [IN_W:0] r_sum;

    generate
        if (c_D > 0) begin : g_rnd_half
            assign w_rnd_off = (IN_W+1)'(1) << (c_D - 1);
        end else begin : g_rnd_none
            assign w_rnd_off = '0;
        end

        // Dither threshold scaled so its full range spans one output LSB
        if (c_D >= 2) begin : g_dith_shl
            assign w_dith_off = (IN_W+1)'(bayer) << (c_D - 2);
        end else begin : g_dith_shr
            assign w_dith_off = (IN_W+1)'(bayer >> (2 - c_D));
        end
    endgenerate

    always_comb begin
        w_off = '0;
        case (mode)
            MODE_ROUND:  w_off = w_rnd_off;
            MODE_DITHER: w_off = w_dith_off;
            default:     w_off = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (en) begin
            r_sum <= {1'b0, pix_in} + w_off;
        end
    end

    assign sat     = r_sum[IN_W];
    assign pix_out = sat ? '1 : OUT_W'(r_sum >> c_D);

endmodule

`default_nettype wire

// File: rtl/ui_pix_conv.sv
// ============================================================================
// Module  : ui_pix_conv
// Brief   : Streaming RGB depth reducer (truncate / round / 2x2 dither), 2-stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ui_pix_conv
    import ui_pix_pkg::*;
#(
    parameter int IN_W = 8,
    parameter int R_W  = 5,
    parameter int G_W  = 6,
    parameter int B_W  = 5,
    localparam int OUT_DW = R_W + G_W + B_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          cfg_mode,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [3*IN_W-1:0]   s_data,
    input  logic                s_sof,
    input  logic                s_eol,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [OUT_DW-1:0]   m_data,
    output logic                m_sof,
    output logic                m_eol,
    output logic [15:0]         sat_cnt
);

    logic              r_v1, r_v2;
    logic              r_sof1, r_eol1;
    logic              r_x, r_y;
    logic [1:0]        r_mode;
    logic [15:0]       r_sat_cnt;
    logic [OUT_DW-1:0] r_m_data;
    logic              r_m_sof, r_m_eol;

    logic              w_acc, w_ld2, w_x, w_y;
    logic [1:0]        w_mode, w_bayer, w_nsat;
    logic [15:0]       w_sat_base;
    logic [16:0]       w_sat_sum;
    logic [R_W-1:0]    w_r;
    logic [G_W-1:0]    w_g;
    logic [B_W-1:0]    w_b;
    logic              w_sat_r, w_sat_g, w_sat_b;

    assign s_ready = ~r_v1 | ~r_v2 | m_ready;
    assign w_acc   = s_valid & s_ready;
    assign w_ld2   = r_v1 & (~r_v2 | m_ready);

    // A sof beat starts the frame with its own mode and position (0,0)
    assign w_x     = s_sof ? 1'b0 : r_x;
    assign w_y     = s_sof ? 1'b0 : r_y;
    assign w_mode  = s_sof ? cfg_mode : r_mode;
    assign w_bayer = bayer_val(w_y, w_x);

    ui_chan_quant #(.IN_W(IN_W), .OUT_W(R_W)) u_quant_r (
        .clk(clk), .rst_n(rst_n), .en(w_acc), .pix_in(s_data[3*IN_W-1:2*IN_W]),
        .mode(w_mode), .bayer(w_bayer), .pix_out(w_r), .sat(w_sat_r)
    );
    ui_chan_quant #(.IN_W(IN_W), .OUT_W(G_W)) u_quant_g (
        .clk(clk), .rst_n(rst_n), .en(w_acc), .pix_in(s_data[2*IN_W-1:IN_W]),
        .mode(w_mode), .bayer(w_bayer), .pix_out(w_g), .sat(w_sat_g)
    );
    ui_chan_quant #(.IN_W(IN_W), .OUT_W(B_W)) u_quant_b (
        .clk(clk), .rst_n(rst_n), .en(w_acc), .pix_in(s_data[IN_W-1:0]),
        .mode(w_mode), .bayer(w_bayer), .pix_out(w_b), .sat(w_sat_b)
    );

    assign w_nsat     = {1'b0, w_sat_r} + {1'b0, w_sat_g} + {1'b0, w_sat_b};
    assign w_sat_base = r_sof1 ? 16'd0 : r_sat_cnt;
    assign w_sat_sum  = {1'b0, w_sat_base} + {15'd0, w_nsat};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_sof1    <= 1'b0;
            r_eol1    <= 1'b0;
            r_x       <= 1'b0;
            r_y       <= 1'b0;
            r_mode    <= MODE_TRUNC;
            r_sat_cnt <= 16'd0;
            r_m_data  <= '0;
            r_m_sof   <= 1'b0;
            r_m_eol   <= 1'b0;
        end else begin
            if (w_acc) begin
                r_v1   <= 1'b1;
                r_sof1 <= s_sof;
                r_eol1 <= s_eol;
                r_x    <= s_eol ? 1'b0 : ~w_x;
                r_y    <= s_eol ? ~w_y : w_y;
                if (s_sof) begin
                    r_mode <= cfg_mode;
                end
            end else if (w_ld2) begin
                r_v1 <= 1'b0;
            end

            if (w_ld2) begin
                r_v2      <= 1'b1;
                r_m_data  <= {w_r, w_g, w_b};
                r_m_sof   <= r_sof1;
                r_m_eol   <= r_eol1;
                r_sat_cnt <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
            end else if (m_ready) begin
                r_v2 <= 1'b0;
            end
        end
    end

    assign m_valid = r_v2;
    assign m_data  = r_m_data;
    assign m_sof   = r_m_sof;
    assign m_eol   = r_m_eol;
    assign sat_cnt = r_sat_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ui_pix_conv.sv
// ============================================================================
// Module  : tb_ui_pix_conv
// Brief   : Scoreboard bench for ui_pix_conv (IN_W=8, 5/6/5) with random traffic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ui_pix_conv;

    typedef struct {
        logic [15:0] d;
        logic        sof;
        logic        eol;
        logic [15:0] sat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  cfg_mode;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic        s_sof;
    logic        s_eol;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_sof;
    logic        m_eol;
    logic [15:0] sat_cnt;

    logic        rnd_rdy;
    logic        rdy_dir;
    logic        rdy_rand;

    int          n_vec;
    int          n_err;
    exp_t        exp_q[$];
    logic [15:0] log_q[$];
    exp_t        mon_e;

    int          mdl_mode;
    int          mdl_x;
    int          mdl_y;
    int          mdl_sat;
    int          bayer_tb[2][2] = '{'{0, 2}, '{3, 1}};

    assign m_ready = rnd_rdy ? rdy_rand : rdy_dir;

    ui_pix_conv #(.IN_W(8), .R_W(5), .G_W(6), .B_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .s_eol(s_eol),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .sat_cnt(sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rdy_rand = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int quant(input int v, input int w, input int md, input int bv,
                                 output bit s);
        int dd  = 8 - w;
        int off = 0;
        int t;
        s = 1'b0;
        if (md == 1 && dd > 0)
            off = 1 << (dd - 1);
        else if (md == 2)
            off = (dd >= 2) ? (bv << (dd - 2)) : (bv >> (2 - dd));
        t = v + off;
        if (t >= 256) begin
            s = 1'b1;
            return (1 << w) - 1;
        end
        return t >> dd;
    endfunction

    task automatic model_accept(input logic [23:0] d, input logic sof, input logic eol,
                                input logic [1:0] cfg);
        exp_t e;
        int   r, g, b, bv, md, ns;
        bit   sr, sg, sb;
        if (sof) begin
            mdl_mode = int'(cfg);
            mdl_x    = 0;
            mdl_y    = 0;
            mdl_sat  = 0;
        end
        md = (mdl_mode == 3) ? 0 : mdl_mode;
        bv = bayer_tb[mdl_y][mdl_x];
        r  = quant(int'(d[23:16]), 5, md, bv, sr);
        g  = quant(int'(d[15:8]),  6, md, bv, sg);
        b  = quant(int'(d[7:0]),   5, md, bv, sb);
        ns = int'(sr) + int'(sg) + int'(sb);
        mdl_sat = (mdl_sat + ns > 65535) ? 65535 : mdl_sat + ns;
        e.d   = 16'(r * 2048 + g * 32 + b);
        e.sof = sof;
        e.eol = eol;
        e.sat = 16'(mdl_sat);
        exp_q.push_back(e);
        if (eol) begin
            mdl_x = 0;
            mdl_y = 1 - mdl_y;
        end else begin
            mdl_x = 1 - mdl_x;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mdl_mode = 0;
        mdl_x    = 0;
        mdl_y    = 0;
        mdl_sat  = 0;
    endtask

    // Monitor: the beat transfers on the next rising edge when valid & ready here
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got %0h with nothing expected", m_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("m_data",  32'(m_data),  32'(mon_e.d));
                chk("m_sof",   32'(m_sof),   32'(mon_e.sof));
                chk("m_eol",   32'(m_eol),   32'(mon_e.eol));
                chk("sat_cnt", 32'(sat_cnt), 32'(mon_e.sat));
            end
            log_q.push_back(m_data);
        end
    end

    task automatic send_beat(input logic [23:0] d, input logic sof, input logic eol);
        int cyc  = 0;
        bit done = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        s_eol   = eol;
        while (!done) begin
            @(negedge clk);
            if (s_ready) begin
                model_accept(d, sof, eol, cfg_mode);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!done && cyc > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: got no s_ready expected accept within 200 cycles");
                done = 1'b1;
            end
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while ((exp_q.size() != 0 || m_valid) && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
        end
    endtask

    initial begin
        logic [15:0] t;
        int          exp_r[4] = '{0, 1, 1, 0};
        logic [15:0] exp_mc[4] = '{16'h8410, 16'h0861, 16'h0861, 16'h1062};

        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        cfg_mode = 2'd0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_sof    = 1'b0;
        s_eol    = 1'b0;
        rnd_rdy  = 1'b0;
        rdy_dir  = 1'b1;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data",  32'(m_data),  32'd0);
        chk("rst_m_sof",   32'(m_sof),   32'd0);
        chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Truncate, latency two edges after accept
        cfg_mode = 2'd0;
        send_beat(24'hFF8040, 1'b1, 1'b0);
        @(negedge clk);
        chk("lat_early_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(m_valid), 32'd1);
        chk("trunc_data", 32'(m_data), 32'h0000FC08);
        chk("trunc_sof", 32'(m_sof), 32'd1);
        chk("trunc_sat", 32'(sat_cnt), 32'd0);
        @(posedge clk);
        #1;
        drain();

        // Round with saturation
        cfg_mode = 2'd1;
        log_q.delete();
        send_beat(24'h0C0C0C, 1'b1, 1'b0);
        send_beat(24'hFFFFFF, 1'b0, 1'b1);
        drain();
        chk("round_cnt", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk("round_data0", 32'(log_q[0]), 32'h00001062);
            chk("round_data1", 32'(log_q[1]), 32'h0000FFFF);
        end
        chk("round_sat_cnt", 32'(sat_cnt), 32'd3);

        // 2x2 dither frame
        cfg_mode = 2'd2;
        log_q.delete();
        send_beat(24'h040404, 1'b1, 1'b0);
        send_beat(24'h040404, 1'b0, 1'b1);
        send_beat(24'h040404, 1'b0, 1'b0);
        send_beat(24'h040404, 1'b0, 1'b1);
        drain();
        chk("dither_cnt", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            t = log_q[i];
            chk("dither_r", 32'(t[15:11]), 32'(exp_r[i]));
        end

        // Mode change mid-frame takes effect only at the next sof
        cfg_mode = 2'd0;
        log_q.delete();
        send_beat(24'h808080, 1'b1, 1'b0);
        cfg_mode = 2'd1;
        send_beat(24'h0C0C0C, 1'b0, 1'b0);
        send_beat(24'h0C0C0C, 1'b0, 1'b1);
        send_beat(24'h0C0C0C, 1'b1, 1'b0);
        drain();
        chk("mode_cnt", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk("mode_data", 32'(log_q[i]), 32'(exp_mc[i]));
        end

        // Downstream stall: two beats held, input blocked, order kept
        rdy_dir = 1'b0;
        send_beat(24'h112233, 1'b0, 1'b0);
        send_beat(24'h445566, 1'b0, 1'b0);
        s_valid = 1'b1;
        s_data  = 24'h778899;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_s_ready", 32'(s_ready), 32'd0);
            chk("stall_m_valid", 32'(m_valid), 32'd1);
            chk("stall_held", 32'(exp_q.size()), 32'd2);
            @(posedge clk);
            #1;
        end
        rdy_dir = 1'b1;
        send_beat(24'h778899, 1'b0, 1'b1);
        drain();

        // Asynchronous reset with both stages full
        rdy_dir = 1'b0;
        send_beat(24'hA0A0A0, 1'b1, 1'b0);
        send_beat(24'hB0B0B0, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_m_valid", 32'(m_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", 32'(m_valid), 32'd0);
        chk("arst_sat_cnt", 32'(sat_cnt), 32'd0);
        model_reset();
        rdy_dir = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);
        chk("post_rst_m_valid", 32'(m_valid), 32'd0);
        @(posedge clk);
        #1;

        // Random traffic with random back-pressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cfg_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_beat(24'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
        end
        rnd_rdy = 1'b0;
        rdy_dir = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
